prbs_checker: RTL and testbench

Serial PRBS-8 checker: receiving end of the on-chip LFSR pattern generator (x^8+x^6+x^5+x^4+1, Fibonacci form). It self-synchronises to an incoming bit stream, declares lock, then counts bit errors against its locally predicted sequence. It sits at the far side of a link or loopback under test and reports lock status and error count to the status/CSR logic.

---
 rtl/prbs_pkg.sv | 22 ++
 rtl/prbs_sat_cnt.sv | 25 ++
 rtl/prbs_checker.sv | 144 ++++++++++++++
 tb/tb_prbs_checker.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/prbs_pkg.sv
// Shared definitions for the PRBS-8 checker: LFSR length, feedback taps,
// FSM state encoding and the next-bit prediction helper.
package prbs_pkg;

    localparam int PRBS_N = 8;
    localparam int TAP_A  = 8;
    localparam int TAP_B  = 6;
    localparam int TAP_C  = 5;
    localparam int TAP_D  = 4;

    typedef enum logic [1:0] {
        SEED,
        VERIFY,
        LOCKED
    } prbs_state_e;

    // Expected next bit of x^8+x^6+x^5+x^4+1 with the newest bit held in s[1].
    function automatic logic prbs_predict(input logic [PRBS_N:1] s);
        return s[TAP_A] ^ s[TAP_B] ^ s[TAP_C] ^ s[TAP_D];
    endfunction

endpackage

// File: rtl/prbs_sat_cnt.sv
// Saturating up-counter with synchronous clear; a clear in the same cycle as
// an increment leaves the counter at 1.
module prbs_sat_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= W'(inc);
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/prbs_checker.sv
// Serial PRBS-8 checker: seeds from the stream, verifies, locks, then counts
// errored bits. Define PRBS_CHECKER_BITCNT_EN to add the checked-bit counter.
module prbs_checker
    import prbs_pkg::*;
#(
    parameter int N          = PRBS_N,
    parameter int VERIFY_LEN = 16,
    parameter int WIN_LEN    = 64,
    parameter int LOSS_THR   = 4,
    parameter int ERR_CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 din,
    input  logic                 din_vld,
    input  logic                 clr_cnt,
    output logic                 locked,
    output logic                 err,
    output logic [ERR_CNT_W-1:0] err_cnt
`ifdef PRBS_CHECKER_BITCNT_EN
    ,
    output logic [31:0]          bit_cnt
`endif
);

    localparam int SEED_W  = $clog2(N);
    localparam int MATCH_W = $clog2(VERIFY_LEN);
    localparam int WBIT_W  = $clog2(WIN_LEN);
    localparam int WERR_W  = $clog2(LOSS_THR + 1);

    prbs_state_e        state, state_nxt;
    logic [N:1]         sreg, sreg_nxt;
    logic [SEED_W-1:0]  seed_cnt, seed_nxt;
    logic [MATCH_W-1:0] match_cnt, match_nxt;
    logic [WBIT_W-1:0]  win_bits, win_bits_nxt;
    logic [WERR_W-1:0]  win_errs, win_errs_nxt, win_errs_sum;
    logic               pred, err_nxt;
    logic [N:1]         shift_din;

    assign pred      = prbs_predict(sreg);
    assign shift_din = {sreg[N-1:1], din};

    // NOTE: every variable driven here gets a default first, otherwise paths
    // that skip an assignment would infer latches.
    always_comb begin
        state_nxt    = state;
        sreg_nxt     = sreg;
        seed_nxt     = seed_cnt;
        match_nxt    = match_cnt;
        win_bits_nxt = win_bits;
        win_errs_nxt = win_errs;
        err_nxt      = 1'b0;
        win_errs_sum = win_errs;

        if (din_vld) begin
            case (state)
                SEED: begin
                    sreg_nxt = shift_din;
                    if (seed_cnt == SEED_W'(N - 1)) begin
                        state_nxt = VERIFY;
                        seed_nxt  = '0;
                        match_nxt = '0;
                    end else begin
                        seed_nxt = seed_cnt + 1'b1;
                    end
                end
                VERIFY: begin
                    sreg_nxt = shift_din;
                    // An all-zero register would predict zeros forever, so it is never trusted.
                    if ((din != pred) || (shift_din == '0)) begin
                        state_nxt = SEED;
                        seed_nxt  = '0;
                    end else if (match_cnt == MATCH_W'(VERIFY_LEN - 1)) begin
                        state_nxt    = LOCKED;
                        win_bits_nxt = '0;
                        win_errs_nxt = '0;
                    end else begin
                        match_nxt = match_cnt + 1'b1;
                    end
                end
                LOCKED: begin
                    // Free-run on the prediction so corrupted input bits never enter the register.
                    sreg_nxt     = {sreg[N-1:1], pred};
                    err_nxt      = (din != pred);
                    win_errs_sum = win_errs + WERR_W'(err_nxt);
                    if (win_errs_sum == WERR_W'(LOSS_THR)) begin
                        state_nxt    = SEED;
                        seed_nxt     = '0;
                        win_bits_nxt = '0;
                        win_errs_nxt = '0;
                    end else if (win_bits == WBIT_W'(WIN_LEN - 1)) begin
                        win_bits_nxt = '0;
                        win_errs_nxt = '0;
                    end else begin
                        win_bits_nxt = win_bits + 1'b1;
                        win_errs_nxt = win_errs_sum;
                    end
                end
                default: state_nxt = SEED;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= SEED;
            sreg      <= '0;
            seed_cnt  <= '0;
            match_cnt <= '0;
            win_bits  <= '0;
            win_errs  <= '0;
            locked    <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_nxt;
            sreg      <= sreg_nxt;
            seed_cnt  <= seed_nxt;
            match_cnt <= match_nxt;
            win_bits  <= win_bits_nxt;
            win_errs  <= win_errs_nxt;
            locked    <= (state_nxt == LOCKED);
            err       <= err_nxt;
        end
    end

    prbs_sat_cnt #(.W(ERR_CNT_W)) u_err_cnt (
        .clk (clk),
        .rst (rst),
        .inc (err_nxt),
        .clr (clr_cnt),
        .cnt (err_cnt)
    );

`ifdef PRBS_CHECKER_BITCNT_EN
    prbs_sat_cnt #(.W(32)) u_bit_cnt (
        .clk (clk),
        .rst (rst),
        .inc (din_vld && (state == LOCKED)),
        .clr (clr_cnt),
        .cnt (bit_cnt)
    );
`endif

endmodule

// File: tb/tb_prbs_checker.sv
// Scoreboard bench for prbs_checker (ERR_CNT_W=4 so saturation is reachable):
// a reference model pushes the expected outputs per driven cycle.
module tb_prbs_checker;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          din = 1'b0;
    logic          din_vld = 1'b0;
    logic          clr_cnt = 1'b0;
    logic          locked;
    logic          err;
    logic [CW-1:0] err_cnt;
`ifdef PRBS_CHECKER_BITCNT_EN
    logic [31:0]   bit_cnt;
`endif

    prbs_checker #(.ERR_CNT_W(CW)) dut (
        .clk     (clk),
        .rst     (rst),
        .din     (din),
        .din_vld (din_vld),
        .clr_cnt (clr_cnt),
        .locked  (locked),
        .err     (err),
        .err_cnt (err_cnt)
`ifdef PRBS_CHECKER_BITCNT_EN
        ,
        .bit_cnt (bit_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        logic          locked;
        logic          err;
        logic [CW-1:0] cnt;
        logic [31:0]   bits;
    } exp_t;

    exp_t sb[$];

    // Reference model state (0 = seeding, 1 = verifying, 2 = locked).
    int          m_state, m_seed, m_match, m_wbits, m_werrs, m_cnt;
    int unsigned m_bits;
    logic [8:1]  m_sreg;

    task automatic model_step(input logic d, input logic v, input logic c, input logic r);
        exp_t e;
        logic p;
        e.err = 1'b0;
        if (!r) begin
            m_state = 0; m_sreg = '0; m_seed = 0; m_match = 0;
            m_wbits = 0; m_werrs = 0; m_cnt = 0; m_bits = 0;
        end else begin
            if (c) begin
                m_cnt  = 0;
                m_bits = 0;
            end
            if (v) begin
                p = ^(m_sreg & 8'hB8);
                if (m_state == 2) begin
                    m_sreg = {m_sreg[7:1], p};
                    if (m_bits != 32'hFFFF_FFFF) m_bits++;
                    m_wbits++;
                    if (d != p) begin
                        e.err = 1'b1;
                        if (m_cnt < (1 << CW) - 1) m_cnt++;
                        m_werrs++;
                    end
                    if (m_werrs == 4) begin
                        m_state = 0; m_seed = 0; m_wbits = 0; m_werrs = 0;
                    end else if (m_wbits == 64) begin
                        m_wbits = 0; m_werrs = 0;
                    end
                end else begin
                    m_sreg = {m_sreg[7:1], d};
                    if (m_state == 0) begin
                        m_seed++;
                        if (m_seed == 8) begin
                            m_state = 1; m_seed = 0; m_match = 0;
                        end
                    end else if ((d != p) || (m_sreg == 8'h00)) begin
                        m_state = 0; m_seed = 0;
                    end else begin
                        m_match++;
                        if (m_match == 16) begin
                            m_state = 2; m_wbits = 0; m_werrs = 0;
                        end
                    end
                end
            end
        end
        e.locked = (m_state == 2);
        e.cnt    = m_cnt[CW-1:0];
        e.bits   = m_bits;
        sb.push_back(e);
    endtask

    int pulses;

    // Drive one cycle, let the model predict, then compare just after the edge.
    task automatic cycle(input logic d, input logic v, input logic c, input logic r);
        exp_t e;
        din = d; din_vld = v; clr_cnt = c; rst = r;
        model_step(d, v, c, r);
        @(posedge clk);
        #1;
        check("sb_depth", sb.size(), 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("locked", locked, e.locked);
            check("err", err, e.err);
            check("err_cnt", err_cnt, e.cnt);
`ifdef PRBS_CHECKER_BITCNT_EN
            check("bit_cnt", bit_cnt, e.bits);
`endif
        end
        if (err === 1'b1) pulses++;
    endtask

    logic [8:1] g;

    task automatic gen_bit(output logic b);
        b = g[8] ^ g[6] ^ g[5] ^ g[4];
        g = {g[7:1], b};
    endtask

    int rise_at, fall_at;

    // n valid generator bits; bits numbered f0..f3 are inverted; alt inserts an
    // invalid cycle carrying junk before each valid bit.
    task automatic run(input int n, input int f0, input int f1, input int f2, input int f3,
                       input bit alt);
        logic b, was;
        rise_at = -1;
        fall_at = -1;
        for (int i = 1; i <= n; i++) begin
            if (alt) cycle(1'($urandom_range(1, 0)), 1'b0, 1'b0, 1'b1);
            gen_bit(b);
            if (i == f0 || i == f1 || i == f2 || i == f3) b = ~b;
            was = locked;
            cycle(b, 1'b1, 1'b0, 1'b1);
            if (!was && locked && rise_at < 0) rise_at = i;
            if (was && !locked && fall_at < 0) fall_at = i;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        logic b;
        int   seen;

        // Reset state
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        check("rst_locked", locked, 0);
        check("rst_err_cnt", err_cnt, 0);

        // Clean stream from seed 0x01: lock after the 24th bit, no errors
        g = 8'h01;
        pulses = 0;
        run(1000, -1, -1, -1, -1, 1'b0);
        check("lock_bit", rise_at, 24);
        check("clean_pulses", pulses, 0);
        check("clean_cnt", err_cnt, 0);

        // Single flipped bit while locked
        pulses = 0;
        run(200, 100, -1, -1, -1, 1'b0);
        check("single_pulses", pulses, 1);
        check("single_cnt", err_cnt, 1);
        check("single_locked", locked, 1);
        check("single_nofall", fall_at, -1);

        // Four errors in one window: loss of lock, relock 24 bits later
        gen_bit(b);
        cycle(b, 1'b1, 1'b1, 1'b1);
        check("clr_cnt", err_cnt, 0);
        pulses = 0;
        run(100, 10, 12, 14, 16, 1'b0);
        check("loss_bit", fall_at, 16);
        check("relock_bit", rise_at, 40);
        check("loss_pulses", pulses, 4);
        check("loss_cnt", err_cnt, 4);

        // All-zero stream never locks
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        seen = 0;
        for (int i = 0; i < 500; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 1'b1);
            if (locked === 1'b1) seen++;
        end
        check("zero_locked", seen, 0);
        check("zero_cnt", err_cnt, 0);

        // din_vld every other cycle
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        g = 8'h01;
        pulses = 0;
        run(100, -1, -1, -1, -1, 1'b1);
        check("gap_lock_bit", rise_at, 24);
        check("gap_pulses", pulses, 0);

        // Isolated errors, one per 64 bits: saturate at 15
        gen_bit(b);
        cycle(b, 1'b1, 1'b1, 1'b1);
        pulses = 0;
        for (int k = 0; k < 20; k++) run(64, 30, -1, -1, -1, 1'b0);
        check("sat_pulses", pulses, 20);
        check("sat_cnt", err_cnt, 15);
        check("sat_locked", locked, 1);

        // clr_cnt concurrent with an errored bit
        gen_bit(b);
        cycle(~b, 1'b1, 1'b1, 1'b1);
        check("clr_err_cnt", err_cnt, 1);
        check("clr_err_pulse", err, 1);

        // Reset while locked
        gen_bit(b);
        check("pre_rst_locked", locked, 1);
        cycle(b, 1'b1, 1'b0, 1'b0);
        check("mid_rst_locked", locked, 0);
        check("mid_rst_err", err, 0);
        check("mid_rst_cnt", err_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
